avl_mem_responder: RTL and testbench

- Synthesizable Avalon-MM responder (slave) standing in for the DDR controller's local interface.
- Lets Avalon masters (memory R/W testers, frame fetch logic) run on-chip and in simulation without the external memory.
- Backs a small word-addressed RAM and models controller init delay, programmable waitrequest stalls and fixed read latency.
- Reports protocol errors and transaction counts.

---
 rtl/avl_mem_responder.sv | 128 ++++++++++++
 tb/tb_avl_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder standing in for the DDR local interface.
// Small word RAM with init delay, waitrequest stalls and fixed read latency.
module avl_mem_responder #(
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = 32,
  parameter int MEM_AW      = 10,
  parameter int INIT_CYCLES = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int READ_LAT    = 3
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic [DATA_W-1:0] avl_writedata,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic              avl_burstbegin,
  output logic              avl_waitrequest_n,
  output logic [DATA_W-1:0] avl_readdata,
  output logic              avl_readdatavalid,
  output logic              local_init_done,
  output logic              proto_err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state_q;
  logic [15:0]         icnt_q;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [READ_LAT-1:0] vp_q;
  logic [DATA_W-1:0]   dp_q [READ_LAT];
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                done_q;
  logic                err_q, err_d;
  logic [15:0]         wrc_q, wrc_d;
  logic [15:0]         rdc_q, rdc_d;

  logic              ready, req, acc, wr_acc, rd_acc, bad;
  logic [MEM_AW-1:0] maddr;
  logic              unused_addr;

  assign maddr       = avl_address[MEM_AW-1:0];
  assign unused_addr = ^avl_address[ADDR_W-1:MEM_AW];

  assign ready  = (state_q == S_READY);
  assign req    = avl_read | avl_write;
  assign acc    = req & avl_waitrequest_n;
  assign wr_acc = acc & avl_write;
  assign rd_acc = acc & avl_read & ~avl_write;
  assign bad    = (avl_read & avl_write)
                | (avl_burstbegin & ~req)
                | (~ready & req);

  // Stall decode depends only on registers.
  assign avl_waitrequest_n = ready && (wcnt_q == 4'(WAIT_CYCLES));

  always_comb begin
    wcnt_d = wcnt_q;
    if (acc)
      wcnt_d = '0;
    else if (req && wcnt_q < 4'(WAIT_CYCLES))
      wcnt_d = wcnt_q + 4'd1;
    err_d = err_q | bad;
    wrc_d = wrc_q;
    if (wr_acc && wrc_q != 16'hFFFF)
      wrc_d = wrc_q + 16'd1;
    rdc_d = rdc_q;
    if (rd_acc && rdc_q != 16'hFFFF)
      rdc_d = rdc_q + 16'd1;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q  <= S_INIT;
      icnt_q   <= '0;
      wcnt_q   <= '0;
      vp_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wrc_q    <= '0;
      rdc_q    <= '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (icnt_q == 16'(INIT_CYCLES - 1)) begin
            state_q <= S_READY;
            done_q  <= 1'b1;
          end else begin
            icnt_q <= icnt_q + 16'd1;
          end
        end
        S_READY: wcnt_q <= wcnt_d;
      endcase
      vp_q     <= {vp_q[READ_LAT-2:0], rd_acc};
      rvalid_q <= vp_q[READ_LAT-1];
      if (vp_q[READ_LAT-1])
        rdata_q <= dp_q[READ_LAT-1];
      err_q <= err_d;
      wrc_q <= wrc_d;
      rdc_q <= rdc_d;
    end
  end

  // RAM and data pipeline carry no reset; the valid pipe qualifies them.
  always_ff @(posedge iCLK) begin
    if (wr_acc)
      mem[maddr] <= avl_writedata;
    dp_q[0] <= mem[maddr];
    for (int i = 1; i < READ_LAT; i++)
      dp_q[i] <= dp_q[i-1];
  end

  assign avl_readdata      = rdata_q;
  assign avl_readdatavalid = rvalid_q;
  assign local_init_done   = done_q;
  assign proto_err         = err_q;
  assign wr_count          = wrc_q;
  assign rd_count          = rdc_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Scoreboard bench for avl_mem_responder.
// Two instances: no-stall (main) and two-cycle stall.
module tb_avl_mem_responder;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] d;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          vec = 0;
  int          errs = 0;
  exp_t        q[$];
  logic [31:0] model [1024];

  logic [26:0] addr0 = '0;
  logic [31:0] wd0 = '0;
  logic        rd0 = 0, wr0 = 0, bb0 = 0;
  logic        wrn0, rv0, done0, err0;
  logic [31:0] rdat0;
  logic [15:0] wc0, rc0;

  logic [26:0] addr1 = '0;
  logic [31:0] wd1 = '0;
  logic        rd1 = 0, wr1 = 0, bb1 = 0;
  logic        wrn1, rv1, done1, err1;
  logic [31:0] rdat1;
  logic [15:0] wc1, rc1;

  avl_mem_responder #(.WAIT_CYCLES(0), .READ_LAT(LAT)) u0 (
    .iCLK(clk), .iRST_n(rst),
    .avl_address(addr0), .avl_writedata(wd0),
    .avl_read(rd0), .avl_write(wr0), .avl_burstbegin(bb0),
    .avl_waitrequest_n(wrn0), .avl_readdata(rdat0),
    .avl_readdatavalid(rv0), .local_init_done(done0),
    .proto_err(err0), .wr_count(wc0), .rd_count(rc0)
  );

  avl_mem_responder #(.WAIT_CYCLES(2), .READ_LAT(LAT)) u1 (
    .iCLK(clk), .iRST_n(rst),
    .avl_address(addr1), .avl_writedata(wd1),
    .avl_read(rd1), .avl_write(wr1), .avl_burstbegin(bb1),
    .avl_waitrequest_n(wrn1), .avl_readdata(rdat1),
    .avl_readdatavalid(rv1), .local_init_done(done1),
    .proto_err(err1), .wr_count(wc1), .rd_count(rc1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rv0 === 1'b1) begin
      if (q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_valid: got valid at cycle %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", rdat0, e.d);
        chk("rd_latency", cyc, e.t);
      end
    end
  end

  task automatic cmd(input logic rd, input logic wr, input logic [26:0] a,
                     input logic [31:0] d, output int waits);
    exp_t e;
    rd0 = rd; wr0 = wr; addr0 = a; wd0 = d;
    waits = 0;
    while (!wrn0 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) chk("accept_timeout", 32'(waits), 32'd0);
    if (wr) begin
      model[a[9:0]] = d;
    end else if (rd) begin
      e.d = model[a[9:0]];
      e.t = cyc + 1 + LAT;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rd0 = 0; wr0 = 0; bb0 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rd0 = 0; wr0 = 0; bb0 = 0; rd1 = 0; wr1 = 0; bb1 = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    q.delete();
  endtask

  task automatic wait_init();
    int n = 0;
    while (!(done0 && done1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_wait", {31'd0, done0}, 32'd1);
  endtask

  initial begin
    int w;
    int lows;
    repeat (3) @(negedge clk);
    chk("rst_wrn", {31'd0, wrn0}, 32'd0);
    chk("rst_valid", {31'd0, rv0}, 32'd0);
    chk("rst_rdata", rdat0, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_counts", {wc0, rc0}, 32'd0);

    rst = 1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 4) begin
        wr0 = 1; addr0 = 27'd1; wd0 = 32'h1;
      end
      if (k == 5) begin
        wr0 = 0;
        chk("init_req_err", {31'd0, err0}, 32'd1);
        chk("init_wr_count", {16'd0, wc0}, 32'd0);
      end
      if (k == 15) chk("init_done_15", {31'd0, done0}, 32'd0);
      if (k == 16) chk("init_done_16", {31'd0, done0}, 32'd1);
    end

    do_reset();
    wait_init();
    chk("err_cleared", {31'd0, err0}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      cmd(0, 1, 27'(i), 32'hAA55AA55, w);
      chk("wr_no_stall", 32'(w), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      cmd(1, 0, 27'(i), 32'h0, w);
      chk("rd_no_stall", 32'(w), 32'd0);
    end
    idle();
    drain();
    chk("wr_count_8", {16'd0, wc0}, 32'd8);
    chk("rd_count_8", {16'd0, rc0}, 32'd8);

    cmd(0, 1, 27'h400, 32'h12345678, w);
    cmd(1, 0, 27'h000, 32'h0, w);
    idle();
    drain();
    chk("alias_no_err", {31'd0, err0}, 32'd0);

    cmd(1, 1, 27'd3, 32'hDEADBEEF, w);
    idle();
    repeat (6) @(negedge clk);
    chk("rw_err", {31'd0, err0}, 32'd1);
    chk("rw_wr_count", {16'd0, wc0}, 32'd10);
    chk("rw_rd_count", {16'd0, rc0}, 32'd9);
    cmd(1, 0, 27'd3, 32'h0, w);
    idle();
    drain();
    chk("rd3_count", {16'd0, rc0}, 32'd10);

    wr1 = 1; addr1 = 27'd5; wd1 = 32'h55;
    lows = 0;
    while (!wrn1 && lows < 20) begin
      @(negedge clk);
      lows++;
    end
    chk("stall_first", 32'(lows), 32'd2);
    @(negedge clk);
    addr1 = 27'd6; wd1 = 32'h66;
    lows = 0;
    while (!wrn1 && lows < 20) begin
      @(negedge clk);
      lows++;
    end
    chk("stall_second", 32'(lows), 32'd2);
    @(negedge clk);
    wr1 = 0;
    chk("stall_wr_count", {16'd0, wc1}, 32'd2);

    cmd(1, 0, 27'd0, 32'h0, w);
    cmd(1, 0, 27'd1, 32'h0, w);
    do_reset();
    chk("mid_rst_valid", {31'd0, rv0}, 32'd0);
    chk("mid_rst_counts", {wc0, rc0}, 32'd0);
    chk("mid_rst_done", {31'd0, done0}, 32'd0);
    chk("mid_rst_wrn", {31'd0, wrn0}, 32'd0);
    repeat (10) @(negedge clk);
    chk("mid_rst_done_still0", {31'd0, done0}, 32'd0);
    wait_init();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
